// File: rtl/multi_dac_spi_cfg.sv
// Sweeps enabled DAC channel words out over SPI (CPOL=0/CPHA=0), one CS frame per channel, then pulses done_o.
// Start to first CS low is 2 cycles with no backpressure. DAC_CFG_AUTO_START_EN adds one start shortly after reset release.
module multi_dac_spi_cfg #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int SCK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic                     dac_clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_word_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [2:0]               ch_idx_o,
  output logic                     dac_sck_o,
  output logic                     dac_cs_n_o,
  output logic                     dac_mosi_o
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, SHIFT, HOLD, GAP, DONE} state_t;

  state_t                    state;
  logic [NUM_CH-1:0]         en_q;
  logic [NUM_CH*DATA_W-1:0]  word_q;
  logic [DATA_W-1:0]         sh_q;
  logic [DIV_W-1:0]          div_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic [GAP_W-1:0]          gap_cnt;
  logic                      start_req;
  logic                      div_last;

  logic                      nxt_found;
  logic [2:0]                nxt_ch;
  logic [DATA_W-1:0]         nxt_word;
  logic [NUM_CH-1:0]         src_en;
  logic [NUM_CH*DATA_W-1:0]  src_word;

`ifdef DAC_CFG_AUTO_START_EN
  logic [1:0] boot_cnt;

  always_ff @(posedge dac_clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt <= '0;
    end else if (boot_cnt != 2'd2) begin
      boot_cnt <= boot_cnt + 2'd1;
    end
  end

  assign start_req = start_i | (boot_cnt == 2'd1);
`else
  assign start_req = start_i;
`endif

  assign div_last = (div_cnt == DIV_W'(SCK_DIV - 1));

  // In LOAD the selection looks at the live inputs (being latched this cycle); afterwards only latched data above the current channel.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    nxt_word  = '0;
    src_en    = (state == LOAD) ? ch_en_i   : en_q;
    src_word  = (state == LOAD) ? ch_word_i : word_q;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (src_en[k] && ((state == LOAD) || (k > int'(ch_idx_o)))) begin
        nxt_found = 1'b1;
        nxt_ch    = 3'(k);
        nxt_word  = src_word[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge dac_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      en_q       <= '0;
      word_q     <= '0;
      sh_q       <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ch_idx_o   <= '0;
      dac_sck_o  <= 1'b0;
      dac_cs_n_o <= 1'b1;
      dac_mosi_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            state  <= LOAD;
            busy_o <= 1'b1;
          end
        end
        LOAD: begin
          en_q    <= ch_en_i;
          word_q  <= ch_word_i;
          div_cnt <= '0;
          if (nxt_found) begin
            state      <= SETUP;
            dac_cs_n_o <= 1'b0;
            dac_mosi_o <= nxt_word[DATA_W-1];
            sh_q       <= nxt_word;
            bit_cnt    <= '0;
            ch_idx_o   <= nxt_ch;
          end else begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        SETUP: begin
          if (div_last) begin
            div_cnt   <= '0;
            state     <= SHIFT;
            dac_sck_o <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (dac_sck_o) begin
              dac_sck_o <= 1'b0;
              // The falling edge after the last bit is the start of HOLD, so MOSI keeps the LSB.
              if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                state <= HOLD;
              end else begin
                bit_cnt    <= bit_cnt + BIT_W'(1);
                dac_mosi_o <= sh_q[DATA_W-2];
                sh_q       <= sh_q << 1;
              end
            end else begin
              dac_sck_o <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HOLD: begin
          if (div_last) begin
            div_cnt    <= '0;
            gap_cnt    <= '0;
            state      <= GAP;
            dac_cs_n_o <= 1'b1;
            dac_mosi_o <= 1'b0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP: begin
          if (div_last) begin
            div_cnt <= '0;
            if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
              if (nxt_found) begin
                state      <= SETUP;
                dac_cs_n_o <= 1'b0;
                dac_mosi_o <= nxt_word[DATA_W-1];
                sh_q       <= nxt_word;
                bit_cnt    <= '0;
                ch_idx_o   <= nxt_ch;
              end else begin
                state  <= DONE;
                done_o <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          busy_o   <= 1'b0;
          ch_idx_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_dac_spi_cfg.sv
// Directed bench: default-parameter instance for sweeps/reset, 24-bit SCK_DIV=1 instance for the fast-frame case.
module tb_multi_dac_spi_cfg;

`ifdef DAC_CFG_AUTO_START_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [3:0]  en_a = '0, en_b = '0;
  logic [63:0] word_a = '0;
  logic [95:0] word_b = '0;
  logic        busy_a, done_a, sck_a, cs_n_a, mosi_a;
  logic        busy_b, done_b, sck_b, cs_n_b, mosi_b;
  logic [2:0]  idx_a, idx_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_dac_spi_cfg u_dut_a (
    .dac_clk(clk), .rst_n(rst_n), .start_i(start_a), .ch_en_i(en_a), .ch_word_i(word_a),
    .busy_o(busy_a), .done_o(done_a), .ch_idx_o(idx_a),
    .dac_sck_o(sck_a), .dac_cs_n_o(cs_n_a), .dac_mosi_o(mosi_a)
  );

  multi_dac_spi_cfg #(.NUM_CH(4), .DATA_W(24), .SCK_DIV(1), .CS_GAP(2)) u_dut_b (
    .dac_clk(clk), .rst_n(rst_n), .start_i(start_b), .ch_en_i(en_b), .ch_word_i(word_b),
    .busy_o(busy_b), .done_o(done_b), .ch_idx_o(idx_b),
    .dac_sck_o(sck_b), .dac_cs_n_o(cs_n_b), .dac_mosi_o(mosi_b)
  );

  // Frame monitor for instance A, sampled on the falling clock edge.
  logic [31:0] fr_word[$];
  int          fr_len[$], fr_idx[$], fr_rises[$], gaps[$];
  logic [31:0] cap_a = '0;
  int          len_a = 0, rises_a = 0, idx_cur_a = 0, gap_run_a = 0;
  int          done_cnt_a = 0, cs_low_tot_a = 0, rise_tot_a = 0;
  logic        cs_prev_a = 1'b1, sck_prev_a = 1'b0;

  always @(negedge clk) begin
    if (!cs_n_a) begin
      if (cs_prev_a) begin
        if (fr_word.size() > 0) gaps.push_back(gap_run_a);
        cap_a = '0; len_a = 0; rises_a = 0; idx_cur_a = int'(idx_a);
      end
      len_a++;
      cs_low_tot_a++;
      if (sck_a && !sck_prev_a) begin
        cap_a = {cap_a[30:0], mosi_a};
        rises_a++;
      end
    end else begin
      if (!cs_prev_a) begin
        fr_word.push_back(cap_a); fr_len.push_back(len_a);
        fr_idx.push_back(idx_cur_a); fr_rises.push_back(rises_a);
        gap_run_a = 0;
      end
      gap_run_a++;
    end
    if (sck_a && !sck_prev_a) rise_tot_a++;
    if (done_a) done_cnt_a++;
    cs_prev_a  = cs_n_a;
    sck_prev_a = sck_a;
  end

  // Lighter monitor for instance B.
  logic [31:0] cap_b = '0, word_last_b = '0;
  int          len_c_b = 0, rise_c_b = 0, mlow_c_b = 0;
  int          len_b = 0, rises_b = 0, mlow_b = 0, idx_last_b = 0, frames_b = 0;
  logic        cs_prev_b = 1'b1, sck_prev_b = 1'b0;

  always @(negedge clk) begin
    if (!cs_n_b) begin
      if (cs_prev_b) begin
        cap_b = '0; len_c_b = 0; rise_c_b = 0; mlow_c_b = 0; idx_last_b = int'(idx_b);
      end
      len_c_b++;
      if (!mosi_b) mlow_c_b++;
      if (sck_b && !sck_prev_b) begin
        cap_b = {cap_b[30:0], mosi_b};
        rise_c_b++;
      end
    end else if (!cs_prev_b) begin
      frames_b++;
      len_b = len_c_b; rises_b = rise_c_b; mlow_b = mlow_c_b; word_last_b = cap_b;
    end
    cs_prev_b  = cs_n_b;
    sck_prev_b = sck_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (!busy_a) return;
    end
    chk("timeout_a", 32'd1, 32'd0);
  endtask

  task automatic clear_a();
    fr_word.delete(); fr_len.delete(); fr_idx.delete(); fr_rises.delete(); gaps.delete();
    done_cnt_a = 0;
  endtask

  int snap_cs, snap_rise, snap_done;

  initial begin
    en_a   = 4'b0001;
    word_a = {16'h0000, 16'h0000, 16'h0000, 16'h5555};
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(cs_n_a), 32'd1);
    chk("rst_sck", 32'(sck_a), 32'd0);
    chk("rst_mosi", 32'(mosi_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_idx", 32'(idx_a), 32'd0);
    rst_n = 1'b1;

    // With no auto-start, nothing may move; with it, one ch0 frame of 0x5555.
    repeat (300) @(posedge clk);
    #1;
    chk("boot_frames", 32'(fr_word.size()), 32'(AUTO));
    chk("boot_done", 32'(done_cnt_a), 32'(AUTO));
    chk("boot_cs_low", 32'(cs_low_tot_a), 32'(AUTO * 33 * 2));
    chk("boot_busy", 32'(busy_a), 32'd0);
    clear_a();

    // Two-channel sweep: ch0 and ch2.
    en_a   = 4'b0101;
    word_a = {16'h0000, 16'h1234, 16'h0000, 16'hA5C3};
    pulse_a();
    wait_idle_a(400);
    chk("sw_frames", 32'(fr_word.size()), 32'd2);
    if (fr_word.size() == 2 && gaps.size() == 1) begin
      chk("sw_word0", fr_word[0], 32'h0000A5C3);
      chk("sw_len0", 32'(fr_len[0]), 32'd66);
      chk("sw_idx0", 32'(fr_idx[0]), 32'd0);
      chk("sw_rises0", 32'(fr_rises[0]), 32'd16);
      chk("sw_word1", fr_word[1], 32'h00001234);
      chk("sw_len1", 32'(fr_len[1]), 32'd66);
      chk("sw_idx1", 32'(fr_idx[1]), 32'd2);
      chk("sw_gap", 32'(gaps[0]), 32'd4);
    end else begin
      chk("sw_shape", 32'(gaps.size()), 32'd1);
    end
    chk("sw_done", 32'(done_cnt_a), 32'd1);
    chk("sw_idx_idle", 32'(idx_a), 32'd0);

    // Empty mask: LOAD then DONE, no SPI activity.
    snap_cs = cs_low_tot_a; snap_rise = rise_tot_a;
    en_a = 4'b0000;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    chk("em_busy_load", 32'(busy_a), 32'd1);
    chk("em_done_load", 32'(done_a), 32'd0);
    @(posedge clk); #1;
    chk("em_done", 32'(done_a), 32'd1);
    chk("em_busy_done", 32'(busy_a), 32'd1);
    @(posedge clk); #1;
    chk("em_done_off", 32'(done_a), 32'd0);
    chk("em_busy_off", 32'(busy_a), 32'd0);
    chk("em_cs", 32'(cs_low_tot_a - snap_cs), 32'd0);
    chk("em_sck", 32'(rise_tot_a - snap_rise), 32'd0);
    clear_a();

    // Inputs and start changed mid-sweep must be ignored.
    en_a   = 4'b0101;
    word_a = {16'h0000, 16'hBEEF, 16'h0000, 16'h0F0F};
    pulse_a();
    repeat (10) @(posedge clk);
    #1;
    en_a   = 4'b1111;
    word_a = {4{16'hFFFF}};
    pulse_a();
    wait_idle_a(400);
    repeat (50) @(posedge clk);
    #1;
    chk("lk_frames", 32'(fr_word.size()), 32'd2);
    if (fr_word.size() == 2) begin
      chk("lk_word0", fr_word[0], 32'h00000F0F);
      chk("lk_word1", fr_word[1], 32'h0000BEEF);
      chk("lk_idx1", 32'(fr_idx[1]), 32'd2);
    end
    chk("lk_done", 32'(done_cnt_a), 32'd1);
    chk("lk_busy", 32'(busy_a), 32'd0);
    clear_a();

    // Reset during bit 7 of ch0 aborts at once, no done, no resume.
    en_a   = 4'b0101;
    word_a = {16'h0000, 16'h1234, 16'h0000, 16'hA5C3};
    pulse_a();
    begin : wait_bit7
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (!cs_n_a && rises_a == 8) disable wait_bit7;
      end
      chk("timeout_bit7", 32'd1, 32'd0);
    end
    rst_n = 1'b0;
    #1;
    chk("ab_cs_n", 32'(cs_n_a), 32'd1);
    chk("ab_sck", 32'(sck_a), 32'd0);
    chk("ab_mosi", 32'(mosi_a), 32'd0);
    chk("ab_busy", 32'(busy_a), 32'd0);
    en_a = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap_cs = cs_low_tot_a; snap_done = done_cnt_a;
    repeat (200) @(posedge clk);
    #1;
    chk("ab_no_done", 32'(snap_done), 32'd0);
    chk("ab_after_done", 32'(done_cnt_a - snap_done), 32'(AUTO));
    chk("ab_after_cs", 32'(cs_low_tot_a - snap_cs), 32'd0);
    chk("ab_after_busy", 32'(busy_a), 32'd0);

    // Fast 24-bit frame on instance B.
    en_b   = 4'b1000;
    word_b = {24'hFFFFFF, 72'h0};
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    begin : wait_b
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (!busy_b) disable wait_b;
      end
      chk("timeout_b", 32'd1, 32'd0);
    end
    chk("fb_frames", 32'(frames_b), 32'd1);
    chk("fb_len", 32'(len_b), 32'd49);
    chk("fb_rises", 32'(rises_b), 32'd24);
    chk("fb_word", word_last_b, 32'h00FFFFFF);
    chk("fb_mosi_low", 32'(mlow_b), 32'd0);
    chk("fb_idx", 32'(idx_last_b), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_dac_spi_cfg.md
MULTI_DAC_SPI_CFG -- requirements
Module: multi_dac_spi_cfg

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DAC channel words per sweep (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, SPI frame width in bits (8..32).
REQ-003 SHALL have parameter SCK_DIV, default 2, SCK half-period T in dac_clk cycles (>=1).
REQ-004 SHALL have parameter CS_GAP, default 2, number of T intervals CS stays high between frames (>=1).
REQ-005 SHALL have port dac_clk, input, 1, the single clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start_i, input, 1, single-cycle sweep request.
REQ-008 SHALL have port ch_en_i, input, NUM_CH, per-channel enable mask.
REQ-009 SHALL have port ch_word_i, input, NUM_CH*DATA_W, frame words; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port busy_o, input-independent output, 1, high from LOAD until DONE.
REQ-011 SHALL have port done_o, output, 1, one-cycle pulse at sweep end.
REQ-012 SHALL have port ch_idx_o, output, 3, index of the channel currently being shifted.
REQ-013 SHALL have ports dac_sck_o, dac_cs_n_o, dac_mosi_o, outputs, 1 each, SPI to DAC.

Function
REQ-014 SHALL implement states IDLE, LOAD, SETUP, SHIFT, HOLD, GAP, DONE.
REQ-015 IDLE: start_i high -> LOAD next cycle; start_i ignored in every other state.
REQ-016 LOAD (1 cycle): latch ch_en_i and ch_word_i; select lowest enabled channel -> SETUP; no enabled channel -> DONE.
REQ-017 SETUP: dac_cs_n_o low, dac_mosi_o = word MSB, dac_sck_o low, for T cycles -> SHIFT.
REQ-018 SHIFT: SCK toggles every T cycles, starting high; MOSI updates to next bit on each falling edge, MSB first (CPOL=0, CPHA=0).
REQ-019 SHIFT SHALL produce exactly DATA_W rising edges, ending with SCK low -> HOLD.
REQ-020 HOLD: CS low, SCK low for T cycles; CS low total = (2*DATA_W+1)*T cycles -> GAP.
REQ-021 GAP: CS high, SCK low, MOSI low for CS_GAP*T cycles; then next higher enabled channel -> SETUP, none left -> DONE.
REQ-022 DONE (1 cycle): done_o high, busy_o low next cycle, return to IDLE.
REQ-023 Inputs changing after LOAD SHALL NOT affect the current sweep.
REQ-024 ch_idx_o SHALL hold the latched channel index from SETUP through GAP; 0 in IDLE.
REQ-025 Bit counter and divider counter SHALL never wrap past DATA_W-1 / SCK_DIV-1.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, dac_cs_n_o=1, dac_sck_o=0, dac_mosi_o=0, busy_o=0, done_o=0, ch_idx_o=0.
REQ-027 Reset mid-frame SHALL abort immediately with no done_o pulse; frame not resumed after release.
REQ-028 No output activity until first start_i after rst_n release (except REQ-030).

Configuration
REQ-029 Macro DAC_CFG_AUTO_START_EN SHALL select auto-start behaviour.
REQ-030 Defined: one internal start generated on the 2nd dac_clk cycle after rst_n release, using current ch_en_i/ch_word_i; start_i still honoured afterwards.
REQ-031 Undefined: sweeps start only from start_i; no auto-start logic present.

Verification (NUM_CH=4, DATA_W=16, SCK_DIV=2, CS_GAP=2)
REQ-032 start_i pulse, ch_en_i=4'b0101, words ch0=16'hA5C3, ch2=16'h1234 -> two CS frames of 66 cycles each, 4-cycle gap, MOSI sampled on SCK rise = A5C3 then 1234, ch_idx_o 0 then 2, one done_o.
REQ-033 ch_en_i=0, start_i -> done_o 2 cycles after start, CS never low, SCK never toggles.
REQ-034 start_i re-pulsed mid-sweep and ch_word_i changed after LOAD -> ignored; transmitted words equal latched values.
REQ-035 rst_n asserted during bit 7 of ch0 -> same-cycle CS=1, SCK=0, MOSI=0, busy_o=0, no done_o.
REQ-036 SCK_DIV=1, DATA_W=24, ch_en_i=4'b1000, word 24'hFFFFFF -> CS low 49 cycles, 24 SCK rises, MOSI high throughout.
REQ-037 DAC_CFG_AUTO_START_EN defined, ch_en_i=4'b0001 at reset release -> frame begins without start_i; undefined -> outputs idle indefinitely.
